// File: rtl/video_pkg.sv
// Shared types and start-code constants for the bitstream scheduler.
package video_pkg;

  localparam int unsigned WIN_W  = 24;
  localparam int unsigned BYTE_W = 8;

  typedef enum logic [2:0] {
    ALIGN = 3'd0,
    HUNT  = 3'd1,
    CODE  = 3'd2,
    HDR   = 3'd3,
    SLICE = 3'd4
  } state_e;

  localparam logic [WIN_W-1:0]  SC_PREFIX = 24'h000001;
  localparam logic [BYTE_W-1:0] PIC       = 8'h00;
  localparam logic [BYTE_W-1:0] SEQ_HDR   = 8'hB3;
  localparam logic [BYTE_W-1:0] EXT       = 8'hB5;
  localparam logic [BYTE_W-1:0] SEQ_END   = 8'hB7;
  localparam logic [BYTE_W-1:0] GOP       = 8'hB8;
  localparam logic [BYTE_W-1:0] SLICE_MAX = 8'hAF;

  typedef struct packed {
    logic is_slice;
    logic is_hdr;
    logic is_end;
    logic is_reserved;
  } sc_class_t;

endpackage

// File: rtl/bitstream_sched_if.sv
// Getbits bit-window channel: window/valid from the getbits unit, advance/align back to it.
interface bitstream_sched_if #(
  parameter int unsigned ADV_W = 5
) ();
  import video_pkg::*;

  logic [WIN_W-1:0] getbits;
  logic             getbits_valid;
  logic [ADV_W-1:0] advance;
  logic             align;

  modport master (
    output getbits,
    output getbits_valid,
    input  advance,
    input  align
  );

  modport slave (
    input  getbits,
    input  getbits_valid,
    output advance,
    output align
  );
endinterface

// File: rtl/start_code_classify.sv
// Maps a start-code value to slice / header / sequence-end / reserved.
module start_code_classify
  import video_pkg::*;
(
  input  logic [BYTE_W-1:0] i_code,
  output sc_class_t         o_class_c
);

  always_comb begin
    o_class_c = '0;
    // Header codes first so that 0x00 is not mistaken for a slice.
    if (i_code == PIC || i_code == SEQ_HDR || i_code == EXT || i_code >= GOP) begin
      o_class_c.is_hdr = 1'b1;
    end else if (i_code <= SLICE_MAX) begin
      o_class_c.is_slice = 1'b1;
    end else if (i_code == SEQ_END) begin
      o_class_c.is_end = 1'b1;
    end else begin
      o_class_c.is_reserved = 1'b1;
    end
  end

endmodule

// File: rtl/bitstream_sched.sv
// Start-code hunter and getbits owner arbitration between header parser and slice VLD.
// Optional slice watchdog enabled by defining SLICE_TIMEOUT_EN.
module bitstream_sched
  import video_pkg::*;
#(
  parameter int unsigned ADV_W = 5,
  parameter int unsigned CNT_W = 16
`ifdef SLICE_TIMEOUT_EN
  ,
  parameter int unsigned TIMEOUT_CYCLES = 65535
`endif
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                i_clk_en,
  bitstream_sched_if.slave    gb,
  output logic                o_vld_en,
  input  logic [ADV_W-1:0]    i_vld_advance,
  input  logic                i_vld_align,
  input  logic                i_slice_end,
  output logic                o_hdr_grant,
  input  logic [ADV_W-1:0]    i_hdr_advance,
  input  logic                i_hdr_align,
  input  logic                i_hdr_done,
  input  logic                i_mb_fifo_afull,
  input  logic                i_sign_counter_fifo_afull,
  input  logic                i_mb_conf_fifo_afull,
  input  logic                i_extend_counter_fifo_afull,
  output logic [BYTE_W-1:0]   o_start_code,
  output logic                o_start_code_valid,
  output logic                o_seq_end,
  output logic                o_code_error,
  output logic [CNT_W-1:0]    o_hunt_skipped,
  output logic                o_timeout
);

  localparam logic [ADV_W-1:0] ADV_WIN  = ADV_W'(WIN_W);
  localparam logic [ADV_W-1:0] ADV_BYTE = ADV_W'(BYTE_W);

  state_e           r_state;
  state_e           w_state_nxt;
  logic [CNT_W-1:0] r_skip;
  logic [CNT_W-1:0] w_skip_nxt;
  logic [CNT_W-1:0] r_hunt_skipped;
  logic [BYTE_W-1:0] r_start_code;
  logic             r_sc_valid;
  logic             r_seq_end;
  logic             r_code_error;

  logic [ADV_W-1:0] w_advance;
  logic             w_align;
  logic             w_vld_en;
  logic             w_skip_latch;
  logic             w_sc_latch;
  logic             w_seq_end;
  logic             w_code_error;
  logic             w_run;
  logic             w_go;
  logic             w_afull;
  logic             w_tmo_hit;
  sc_class_t        w_class;

  start_code_classify u_classify (
    .i_code    (gb.getbits[WIN_W-1 -: BYTE_W]),
    .o_class_c (w_class)
  );

  // Reset also silences the combinational controls so nothing is consumed while held.
  assign w_run   = i_clk_en & ~rst;
  assign w_go    = w_run & gb.getbits_valid;
  assign w_afull = i_mb_fifo_afull | i_sign_counter_fifo_afull
                 | i_mb_conf_fifo_afull | i_extend_counter_fifo_afull;

`ifdef SLICE_TIMEOUT_EN
  localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  logic [CNT_W-1:0] r_tmo_cnt;
  logic             r_timeout;

  // Counter sits at zero outside SLICE, so every SLICE visit starts fresh.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_tmo_cnt <= '0;
      r_timeout <= 1'b0;
    end else if (i_clk_en) begin
      r_tmo_cnt <= (r_state == SLICE) ? r_tmo_cnt + CNT_W'(1) : '0;
      r_timeout <= w_tmo_hit & ~i_slice_end;
    end
  end

  assign w_tmo_hit = (r_state == SLICE) && (r_tmo_cnt == TMO_LAST);
  assign o_timeout = r_timeout;
`else
  assign w_tmo_hit = 1'b0;
  assign o_timeout = 1'b0;
`endif

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ALIGN;
    end else if (i_clk_en) begin
      r_state <= w_state_nxt;
    end
  end

  // Next state and getbits controls.
  always_comb begin
    w_state_nxt  = r_state;
    w_advance    = '0;
    w_align      = 1'b0;
    w_vld_en     = 1'b0;
    w_skip_nxt   = r_skip;
    w_skip_latch = 1'b0;
    w_sc_latch   = 1'b0;
    w_seq_end    = 1'b0;
    w_code_error = 1'b0;
    case (r_state)
      ALIGN: begin
        if (w_go) begin
          w_align     = 1'b1;
          w_skip_nxt  = '0;
          w_state_nxt = HUNT;
        end
      end
      HUNT: begin
        if (w_go) begin
          if (gb.getbits == SC_PREFIX) begin
            w_advance    = ADV_WIN;
            w_skip_latch = 1'b1;
            w_state_nxt  = CODE;
          end else begin
            w_advance = ADV_BYTE;
            if (r_skip != '1) begin
              w_skip_nxt = r_skip + CNT_W'(1);
            end
          end
        end
      end
      CODE: begin
        if (w_go) begin
          w_advance  = ADV_BYTE;
          w_sc_latch = 1'b1;
          if (w_class.is_slice) begin
            w_state_nxt = SLICE;
          end else if (w_class.is_hdr) begin
            w_state_nxt = HDR;
          end else if (w_class.is_end) begin
            w_seq_end   = 1'b1;
            w_state_nxt = ALIGN;
          end else begin
            w_code_error = 1'b1;
            w_state_nxt  = ALIGN;
          end
        end
      end
      HDR: begin
        if (w_run) begin
          if (gb.getbits_valid) begin
            w_advance = i_hdr_advance;
            w_align   = i_hdr_align;
          end
          if (i_hdr_done) begin
            w_state_nxt = ALIGN;
          end
        end
      end
      SLICE: begin
        if (w_run) begin
          w_vld_en = gb.getbits_valid & ~w_afull & ~w_tmo_hit;
          if (w_vld_en) begin
            w_advance = i_vld_advance;
            w_align   = i_vld_align;
          end
          if (i_slice_end || w_tmo_hit) begin
            w_state_nxt = ALIGN;
          end
        end
      end
      default: w_state_nxt = ALIGN;
    endcase
  end

  // Hunt counter, latched code and event pulses.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_skip         <= '0;
      r_hunt_skipped <= '0;
      r_start_code   <= '0;
      r_sc_valid     <= 1'b0;
      r_seq_end      <= 1'b0;
      r_code_error   <= 1'b0;
    end else if (i_clk_en) begin
      r_skip       <= w_skip_nxt;
      r_sc_valid   <= w_sc_latch;
      r_seq_end    <= w_seq_end;
      r_code_error <= w_code_error;
      if (w_skip_latch) begin
        r_hunt_skipped <= r_skip;
      end
      if (w_sc_latch) begin
        r_start_code <= gb.getbits[WIN_W-1 -: BYTE_W];
      end
    end
  end

  assign gb.advance         = w_advance;
  assign gb.align           = w_align;
  assign o_vld_en           = w_vld_en;
  assign o_hdr_grant        = (r_state == HDR);
  assign o_start_code       = r_start_code;
  assign o_start_code_valid = r_sc_valid;
  assign o_seq_end          = r_seq_end;
  assign o_code_error       = r_code_error;
  assign o_hunt_skipped     = r_hunt_skipped;

endmodule

// File: tb/tb_bitstream_sched.sv
// Vector table for the combinational getbits controls, event scoreboard for registered pulses.
module tb_bitstream_sched;
  import video_pkg::*;

  localparam int unsigned ADV_W = 5;
  localparam int unsigned CNT_W = 16;

  localparam logic [1:0] K_NONE = 2'd0;
  localparam logic [1:0] K_SC   = 2'd1;
  localparam logic [1:0] K_END  = 2'd2;
  localparam logic [1:0] K_ERR  = 2'd3;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic             clk_en;
  logic [ADV_W-1:0] vld_advance;
  logic             vld_align;
  logic             slice_end;
  logic [ADV_W-1:0] hdr_advance;
  logic             hdr_align;
  logic             hdr_done;
  logic [3:0]       afull;
  logic             vld_en;
  logic             hdr_grant;
  logic [7:0]       start_code;
  logic             sc_valid;
  logic             seq_end;
  logic             code_error;
  logic [CNT_W-1:0] hunt_skipped;
  logic             timeout;

  bitstream_sched_if #(.ADV_W(ADV_W)) gb_if ();

  bitstream_sched #(
    .ADV_W(ADV_W),
    .CNT_W(CNT_W)
`ifdef SLICE_TIMEOUT_EN
    ,
    .TIMEOUT_CYCLES(10)
`endif
  ) dut (
    .clk                         (clk),
    .rst                         (rst),
    .i_clk_en                    (clk_en),
    .gb                          (gb_if.slave),
    .o_vld_en                    (vld_en),
    .i_vld_advance               (vld_advance),
    .i_vld_align                 (vld_align),
    .i_slice_end                 (slice_end),
    .o_hdr_grant                 (hdr_grant),
    .i_hdr_advance               (hdr_advance),
    .i_hdr_align                 (hdr_align),
    .i_hdr_done                  (hdr_done),
    .i_mb_fifo_afull             (afull[0]),
    .i_sign_counter_fifo_afull   (afull[1]),
    .i_mb_conf_fifo_afull        (afull[2]),
    .i_extend_counter_fifo_afull (afull[3]),
    .o_start_code                (start_code),
    .o_start_code_valid          (sc_valid),
    .o_seq_end                   (seq_end),
    .o_code_error                (code_error),
    .o_hunt_skipped              (hunt_skipped),
    .o_timeout                   (timeout)
  );

  typedef struct {
    logic             en;
    logic             v;
    logic [23:0]      gbits;
    logic [3:0]       afull;
    logic [ADV_W-1:0] vadv;
    logic             valn;
    logic             send;
    logic [ADV_W-1:0] hadv;
    logic             haln;
    logic             hdone;
    logic [ADV_W-1:0] e_adv;
    logic             e_aln;
    logic             e_vld;
    logic             e_grant;
    logic [1:0]       ev_kind;
    logic [7:0]       ev_code;
    logic [CNT_W-1:0] ev_skip;
  } vec_t;

  typedef struct {
    logic [7:0]       code;
    logic             scv;
    logic             send;
    logic             err;
    logic             tmo;
    logic [CNT_W-1:0] skip;
  } ev_t;

  vec_t tbl[$];
  ev_t  exp_q[$];
  ev_t  got_ev;
  int   checks = 0;
  int   errors = 0;

  task automatic chk(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s vec=%0d got=%0h want=%0h", name, idx, act, exp);
    end
  endtask

  task automatic add(input logic en, input logic v, input logic [23:0] g, input logic [3:0] af,
                     input logic [ADV_W-1:0] vadv, input logic valn, input logic send,
                     input logic [ADV_W-1:0] hadv, input logic haln, input logic hdone,
                     input logic [ADV_W-1:0] e_adv, input logic e_aln, input logic e_vld,
                     input logic e_grant, input logic [1:0] kind, input logic [7:0] code,
                     input logic [CNT_W-1:0] skip);
    vec_t t;
    t = '{en, v, g, af, vadv, valn, send, hadv, haln, hdone,
          e_adv, e_aln, e_vld, e_grant, kind, code, skip};
    tbl.push_back(t);
  endtask

  // Drive one vector at the falling edge and check the combinational controls 1ns later.
  task automatic run_table();
    ev_t e;
    for (int i = 0; i < tbl.size(); i++) begin
      @(negedge clk);
      clk_en               = tbl[i].en;
      gb_if.getbits_valid  = tbl[i].v;
      gb_if.getbits        = tbl[i].gbits;
      afull                = tbl[i].afull;
      vld_advance          = tbl[i].vadv;
      vld_align            = tbl[i].valn;
      slice_end            = tbl[i].send;
      hdr_advance          = tbl[i].hadv;
      hdr_align            = tbl[i].haln;
      hdr_done             = tbl[i].hdone;
      if (tbl[i].ev_kind != K_NONE) begin
        e.code = tbl[i].ev_code;
        e.scv  = 1'b1;
        e.send = (tbl[i].ev_kind == K_END);
        e.err  = (tbl[i].ev_kind == K_ERR);
        e.tmo  = 1'b0;
        e.skip = tbl[i].ev_skip;
        exp_q.push_back(e);
      end
      #1;
      chk("advance", i, 32'(gb_if.advance), 32'(tbl[i].e_adv));
      chk("align", i, 32'(gb_if.align), 32'(tbl[i].e_aln));
      chk("vld_en", i, 32'(vld_en), 32'(tbl[i].e_vld));
      chk("hdr_grant", i, 32'(hdr_grant), 32'(tbl[i].e_grant));
    end
    tbl.delete();
  endtask

  // Every registered pulse must match the next expected event in order.
  always @(negedge clk) begin
    if (!rst && (sc_valid || seq_end || code_error || timeout)) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_pulse", 0, {28'd0, sc_valid, seq_end, code_error, timeout}, 32'd0);
      end else begin
        got_ev = exp_q.pop_front();
        chk("ev_start_code", 0, 32'(start_code), 32'(got_ev.code));
        chk("ev_sc_valid", 0, 32'(sc_valid), 32'(got_ev.scv));
        chk("ev_seq_end", 0, 32'(seq_end), 32'(got_ev.send));
        chk("ev_code_error", 0, 32'(code_error), 32'(got_ev.err));
        chk("ev_timeout", 0, 32'(timeout), 32'(got_ev.tmo));
        chk("ev_hunt_skipped", 0, 32'(hunt_skipped), 32'(got_ev.skip));
      end
    end
  end

  initial begin
    ev_t e;
    rst = 1'b1;
    clk_en = 1'b1;
    gb_if.getbits_valid = 1'b1;
    gb_if.getbits = 24'h000001;
    afull = 4'h0;
    vld_advance = '0; vld_align = 1'b0; slice_end = 1'b0;
    hdr_advance = '0; hdr_align = 1'b0; hdr_done = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    chk("rst_advance", 0, 32'(gb_if.advance), 32'd0);
    chk("rst_align", 0, 32'(gb_if.align), 32'd0);
    chk("rst_vld_en", 0, 32'(vld_en), 32'd0);
    chk("rst_hdr_grant", 0, 32'(hdr_grant), 32'd0);
    chk("rst_start_code", 0, 32'(start_code), 32'd0);
    chk("rst_pulses", 0, {28'd0, sc_valid, seq_end, code_error, timeout}, 32'd0);
    chk("rst_hunt_skipped", 0, 32'(hunt_skipped), 32'd0);
    gb_if.getbits_valid = 1'b0;
    rst = 1'b0;

    //   en v gbits        af    vadv valn send hadv haln hdone  adv aln vld gnt kind   code   skip
    add(1, 1, 24'h123400, 4'h0, 0, 0, 0, 0, 0, 0,   0, 1, 0, 0, K_NONE, 8'h00, 0);
    add(1, 1, 24'h123400, 4'h0, 0, 0, 0, 0, 0, 0,   8, 0, 0, 0, K_NONE, 8'h00, 0);
    add(1, 1, 24'h340000, 4'h0, 0, 0, 0, 0, 0, 0,   8, 0, 0, 0, K_NONE, 8'h00, 0);
    add(1, 1, 24'h000001, 4'h0, 0, 0, 0, 0, 0, 0,  24, 0, 0, 0, K_NONE, 8'h00, 0);
    add(1, 1, 24'hB31234, 4'h0, 0, 0, 0, 0, 0, 0,   8, 0, 0, 0, K_SC,   8'hB3, 2);
    add(1, 1, 24'h0A0B0C, 4'h0, 0, 0, 0, 12, 0, 1, 12, 0, 0, 1, K_NONE, 8'h00, 0);
    add(1, 1, 24'h000000, 4'h0, 0, 0, 0, 0, 0, 0,   0, 1, 0, 0, K_NONE, 8'h00, 0);
    add(1, 1, 24'h000001, 4'h0, 0, 0, 0, 0, 0, 0,  24, 0, 0, 0, K_NONE, 8'h00, 0);
    add(1, 1, 24'h05FFFF, 4'h0, 0, 0, 0, 0, 0, 0,   8, 0, 0, 0, K_SC,   8'h05, 0);
    add(1, 1, 24'h111111, 4'h1, 7, 0, 0, 0, 0, 0,   0, 0, 0, 0, K_NONE, 8'h00, 0);
    add(1, 1, 24'h111111, 4'h0, 7, 0, 0, 0, 0, 0,   7, 0, 1, 0, K_NONE, 8'h00, 0);
    add(1, 1, 24'h111111, 4'h1, 3, 0, 0, 0, 0, 0,   0, 0, 0, 0, K_NONE, 8'h00, 0);
    add(1, 1, 24'h111111, 4'h2, 3, 1, 0, 0, 0, 0,   0, 0, 0, 0, K_NONE, 8'h00, 0);
    add(1, 0, 24'h111111, 4'h0, 3, 1, 0, 0, 0, 0,   0, 0, 0, 0, K_NONE, 8'h00, 0);
    add(0, 1, 24'h111111, 4'h0, 6, 0, 0, 0, 0, 0,   0, 0, 0, 0, K_NONE, 8'h00, 0);
    add(1, 1, 24'h111111, 4'h0, 0, 1, 0, 0, 0, 0,   0, 1, 1, 0, K_NONE, 8'h00, 0);
    add(1, 1, 24'h111111, 4'h0, 4, 0, 1, 0, 0, 0,   4, 0, 1, 0, K_NONE, 8'h00, 0);
    add(1, 0, 24'h000001, 4'h0, 0, 0, 0, 5, 1, 0,   0, 0, 0, 0, K_NONE, 8'h00, 0);
    add(1, 1, 24'h000001, 4'h0, 0, 0, 0, 5, 1, 0,   0, 1, 0, 0, K_NONE, 8'h00, 0);
    add(1, 0, 24'h000001, 4'h0, 0, 0, 0, 0, 0, 0,   0, 0, 0, 0, K_NONE, 8'h00, 0);
    add(1, 1, 24'h000001, 4'h0, 0, 0, 0, 0, 0, 0,  24, 0, 0, 0, K_NONE, 8'h00, 0);
    add(1, 0, 24'hB40000, 4'h0, 0, 0, 0, 0, 0, 0,   0, 0, 0, 0, K_NONE, 8'h00, 0);
    add(1, 1, 24'hB40000, 4'h0, 0, 0, 0, 0, 0, 0,   8, 0, 0, 0, K_ERR,  8'hB4, 0);
    add(1, 1, 24'h000000, 4'h0, 3, 0, 0, 0, 0, 0,   0, 1, 0, 0, K_NONE, 8'h00, 0);
    add(1, 1, 24'hAA0000, 4'h0, 0, 0, 0, 0, 0, 0,   8, 0, 0, 0, K_NONE, 8'h00, 0);
    add(1, 1, 24'h000001, 4'h0, 0, 0, 0, 0, 0, 0,  24, 0, 0, 0, K_NONE, 8'h00, 0);
    add(1, 1, 24'hB70000, 4'h0, 0, 0, 0, 0, 0, 0,   8, 0, 0, 0, K_END,  8'hB7, 1);
    add(1, 1, 24'h000000, 4'h0, 0, 0, 0, 0, 0, 0,   0, 1, 0, 0, K_NONE, 8'h00, 0);
    add(1, 1, 24'h000001, 4'h0, 0, 0, 0, 0, 0, 0,  24, 0, 0, 0, K_NONE, 8'h00, 0);
    add(1, 1, 24'h00ABCD, 4'h0, 0, 0, 0, 0, 0, 0,   8, 0, 0, 0, K_SC,   8'h00, 0);
    add(1, 0, 24'h222222, 4'h0, 0, 0, 0, 9, 0, 0,   0, 0, 0, 1, K_NONE, 8'h00, 0);
    add(1, 1, 24'h222222, 4'h0, 0, 0, 0, 9, 0, 0,   9, 0, 0, 1, K_NONE, 8'h00, 0);
    add(1, 1, 24'h222222, 4'h0, 0, 0, 0, 0, 1, 0,   0, 1, 0, 1, K_NONE, 8'h00, 0);
    add(0, 1, 24'h222222, 4'h0, 0, 0, 0, 3, 0, 1,   0, 0, 0, 1, K_NONE, 8'h00, 0);
    add(1, 1, 24'h222222, 4'h0, 0, 0, 1, 2, 0, 0,   2, 0, 0, 1, K_NONE, 8'h00, 0);
    run_table();

    // Asynchronous reset in the middle of a header grant.
    #2;
    rst = 1'b1;
    #1;
    chk("midrst_hdr_grant", 0, 32'(hdr_grant), 32'd0);
    chk("midrst_advance", 0, 32'(gb_if.advance), 32'd0);
    chk("midrst_start_code", 0, 32'(start_code), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    hdr_advance = '0;
    slice_end = 1'b0;
    gb_if.getbits_valid = 1'b1;
    #1;
    chk("postrst_align", 0, 32'(gb_if.align), 32'd1);
    chk("postrst_hdr_grant", 0, 32'(hdr_grant), 32'd0);

    add(1, 1, 24'h000001, 4'h0, 0, 0, 0, 0, 0, 0,  24, 0, 0, 0, K_NONE, 8'h00, 0);
    add(1, 1, 24'h053333, 4'h0, 0, 0, 0, 0, 0, 0,   8, 0, 0, 0, K_SC,   8'h05, 0);
`ifdef SLICE_TIMEOUT_EN
    for (int k = 0; k < 9; k++) begin
      add(1, 1, 24'h444444, 4'h0, 1, 0, 0, 0, 0, 0, 1, 0, 1, 0, K_NONE, 8'h00, 0);
    end
    add(1, 1, 24'h444444, 4'h0, 1, 0, 0, 0, 0, 0,   0, 0, 0, 0, K_NONE, 8'h00, 0);
    run_table();
    e.code = 8'h05; e.scv = 1'b0; e.send = 1'b0; e.err = 1'b0; e.tmo = 1'b1; e.skip = '0;
    exp_q.push_back(e);
    add(1, 1, 24'h444444, 4'h0, 0, 0, 0, 0, 0, 0,   0, 1, 0, 0, K_NONE, 8'h00, 0);
`else
    add(1, 0, 24'h444444, 4'h0, 6, 0, 1, 0, 0, 0,   0, 0, 0, 0, K_NONE, 8'h00, 0);
    add(1, 1, 24'h444444, 4'h0, 6, 0, 0, 0, 0, 0,   0, 1, 0, 0, K_NONE, 8'h00, 0);
`endif
    run_table();

    repeat (2) @(negedge clk);
    #1;
    chk("events_drained", 0, 32'(exp_q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/bitstream_sched.md
Name: bitstream_sched

Overview:
- Top-level sequencer for the shared getbits bit-window in the video decoder.
- Hunts for byte-aligned MPEG start codes (0x000001xx).
- Grants the getbits advance/align controls to the header parser or to the slice VLD, according to the start-code value.
- Generates vld_en from downstream FIFO almost-full flags.

Parameters:
- ADV_W, 5, width of advance fields (max advance 24)
- CNT_W, 16, width of the skipped-byte counter
- TIMEOUT_CYCLES, 65535, watchdog limit in SLICE (used only with the optional feature)

Ports:
- clk  in  1  system clock
- rst  in  1  reset
- clk_en  in  1  global clock enable; all state frozen when low
- getbits  in  24  current bit window, MSB = next bit
- getbits_valid  in  1  window valid this cycle
- advance  out  ADV_W  bits consumed this cycle (to getbits)
- align  out  1  skip to next byte boundary (to getbits)
- vld_en  out  1  VLD step enable
- vld_advance  in  ADV_W  VLD-requested advance
- vld_align  in  1  VLD-requested align
- slice_end  in  1  VLD finished slice
- hdr_grant  out  1  header parser owns getbits
- hdr_advance  in  ADV_W  header-parser advance
- hdr_align  in  1  header-parser align
- hdr_done  in  1  header parsing finished
- mb_fifo_afull  in  1  downstream almost-full
- sign_counter_fifo_afull  in  1  downstream almost-full
- mb_conf_fifo_afull  in  1  downstream almost-full
- extend_counter_fifo_afull  in  1  downstream almost-full
- start_code  out  8  last start-code value
- start_code_valid  out  1  one-cycle pulse
- seq_end  out  1  pulse on code 0xB7
- code_error  out  1  pulse on reserved code
- hunt_skipped  out  CNT_W  bytes skipped in the last hunt, saturating
- timeout  out  1  watchdog pulse (0 without the optional feature)

Behaviour:
- Interface (already decided): one clock, clk; reset rst is asynchronous and active-high.
- Reset values:
  - state = ALIGN.
  - advance=0, align=0, vld_en=0, hdr_grant=0.
  - All pulses = 0; start_code = 0x00; hunt_skipped = 0.
- clk_en low: state, counters and pulses hold; advance=0, align=0, vld_en=0 combinationally.
- Consumption rule: a nonzero advance or align is driven only when getbits_valid=1. The window is treated as stale until getbits_valid is seen again.
- advance, align, vld_en and hdr_grant are combinational from state and inputs. start_code, the pulses and hunt_skipped are registered, one cycle after the event.
- ALIGN:
  - Drive align=1 for one valid cycle.
  - Clear the hunt byte counter.
  - Go to HUNT.
- HUNT, on each valid cycle:
  - If getbits == 24'h000001: advance=24, register hunt_skipped, go to CODE.
  - Otherwise: advance=8, skip counter +1, saturating at all-ones.
- CODE, on a valid cycle:
  - Latch start_code = getbits[23:16], advance=8, pulse start_code_valid.
  - Next state by code:
    - 0x01..0xAF: SLICE.
    - 0x00, 0xB3, 0xB5, 0xB8, 0xB9..0xFF: HDR.
    - 0xB7: pulse seq_end, go to ALIGN.
    - 0xB0, 0xB1, 0xB2, 0xB4, 0xB6: pulse code_error, go to ALIGN.
- HDR:
  - hdr_grant=1; advance = hdr_advance and align = hdr_align, each gated by getbits_valid.
  - On hdr_done, the same-cycle advance is honoured, then go to ALIGN.
- SLICE:
  - vld_en = getbits_valid & ~(OR of the four afull flags).
  - advance = vld_advance and align = vld_align, each gated by vld_en.
  - On slice_end, the same-cycle advance is honoured, then go to ALIGN.
  - slice_end with vld_en=0 still exits.
- Ignored inputs: hdr_* are ignored outside HDR; vld_* and slice_end are ignored outside SLICE.
- Async reset mid-operation returns immediately to the reset values. The first action after reset is align.

Optional Feature:
- Macro: SLICE_TIMEOUT_EN.
- Defined:
  - A CNT_W-wide cycle counter runs while in SLICE with clk_en=1; it clears on entry to SLICE.
  - On reaching TIMEOUT_CYCLES: pulse timeout and force ALIGN. vld_en=0 in that cycle.
  - slice_end in the same cycle wins, with no timeout pulse.
- Undefined: no counter; timeout is tied to 0.

Decomposition:
- Shared package (video_pkg):
  - State enum {ALIGN, HUNT, CODE, HDR, SLICE}.
  - Start-code constants SC_PREFIX=24'h000001, PIC=8'h00, SEQ_HDR=8'hB3, EXT=8'hB5, SEQ_END=8'hB7, GOP=8'hB8, SLICE_MAX=8'hAF.
- Sub-module start_code_classify: combinational code -> {is_slice, is_hdr, is_end, is_reserved}.

Test Plan:
- Reset then stream 0x12 0x34 0x00 0x00 0x01 0xB3 -> align pulse; two advance=8; advance=24; start_code=0xB3, start_code_valid; hunt_skipped=2; hdr_grant=1.
- Code 0x05 with mb_fifo_afull toggling 1,0,1 -> vld_en follows ~afull; advance=vld_advance only when vld_en=1; slice_end -> align on the next valid cycle.
- hdr_done in the same cycle as hdr_advance=12 -> advance=12, then ALIGN then HUNT.
- Code 0xB4 -> code_error pulse, no grant; code 0xB7 -> seq_end pulse.
- getbits_valid low during HUNT/CODE/HDR/SLICE -> advance=0 and state held; clk_en low mid-SLICE -> vld_en=0, state held.
- With SLICE_TIMEOUT_EN and TIMEOUT_CYCLES=10, no slice_end -> timeout pulse after 10 SLICE cycles, then align; async rst asserted mid-HDR -> hdr_grant=0 at once.
